// File: rtl/rs422_tx_scheduler_pkg.sv
// Shared constants for the RS422 frame scheduler: byte width, default sync byte, FSM encodings.
// Optional checksum state ST_CSUM is only reachable when RS422_TX_CSUM_EN is defined.
package rs422_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hEB;

    typedef logic [3:0] state_t;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_SYNC = 4'd1;
    localparam logic [3:0] ST_CHID = 4'd2;
    localparam logic [3:0] ST_LEN  = 4'd3;
    localparam logic [3:0] ST_RD   = 4'd4;
    localparam logic [3:0] ST_WT   = 4'd5;
    localparam logic [3:0] ST_DATA = 4'd6;
    localparam logic [3:0] ST_CSUM = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

endpackage

// File: rtl/rs422_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after rr_ptr,
// wrapping modulo NCH, and returns it both one-hot and as an index.
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int IDXW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic [NCH-1:0]  gnt_onehot,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, rr_ptr} + (IDXW+1)'(k);
            if (sum >= (IDXW+1)'(NCH)) begin
                sum = sum - (IDXW+1)'(NCH);
            end
            cand = sum[IDXW-1:0];
            if (!gnt_any && req[cand]) begin
                gnt_any          = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs422_tx_scheduler.sv
// Round-robin scheduler framing NCH byte FIFOs onto one RS422 byte transmitter.
// Define RS422_TX_CSUM_EN to append an XOR checksum byte (CHID, LEN, payload) to each frame.
module rs422_tx_scheduler
    import rs422_pkg::*;
#(
    parameter int                NCH       = 4,
    parameter int                PTRWIDTH  = 9,
    parameter int                MAX_BURST = 64,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            fifo_empty,
    input  logic [NCH*(PTRWIDTH+1)-1:0] fifo_usedw,
    input  logic [NCH*8-1:0]          fifo_dout,
    input  logic [NCH-1:0]            fifo_valid,
    output logic [NCH-1:0]            fifo_load,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int IDXW = $clog2(NCH);
    localparam int UW   = PTRWIDTH + 1;
    localparam logic [UW-1:0] MAX_BURST_UW = UW'(MAX_BURST);

    state_t                state_q, state_d;
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]       gnt_q, gnt_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
`ifdef RS422_TX_CSUM_EN
    logic [BYTE_W-1:0]     csum_q, csum_d;
`endif

    logic [NCH-1:0]        arb_onehot;
    logic [IDXW-1:0]       arb_idx;
    logic                  arb_any;
    logic [UW-1:0]         usedw_sel;
    logic [BYTE_W-1:0]     dout_sel;
    logic                  valid_sel;
    logic                  tx_hs;

    rr_arbiter #(.NCH(NCH), .IDXW(IDXW)) u_arb (
        .req        (~fifo_empty),
        .rr_ptr     (rr_ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    assign usedw_sel = fifo_usedw[arb_idx*UW +: UW];
    assign dout_sel  = fifo_dout[gnt_q*8 +: 8];
    assign valid_sel = fifo_valid[gnt_q];
    assign tx_hs     = tx_valid_q && tx_ready;

    // tx_data/tx_valid only move on a handshake or while tx_valid is low, so a stalled byte is held.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef RS422_TX_CSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef RS422_TX_CSUM_EN
                csum_d = '0;
`endif
                if (arb_any) begin
                    gnt_d      = arb_idx;
                    len_d      = (usedw_sel > MAX_BURST_UW) ? 8'(MAX_BURST) : 8'(usedw_sel);
                    cnt_d      = '0;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = ST_SYNC;
                end
            end
            ST_SYNC: if (tx_hs) begin
                tx_data_d = 8'(gnt_q);
                state_d   = ST_CHID;
            end
            ST_CHID: if (tx_hs) begin
`ifdef RS422_TX_CSUM_EN
                csum_d = csum_q ^ tx_data_q;
`endif
                tx_data_d = len_q;
                state_d   = ST_LEN;
            end
            ST_LEN: if (tx_hs) begin
`ifdef RS422_TX_CSUM_EN
                csum_d = csum_q ^ tx_data_q;
`endif
                tx_valid_d = 1'b0;
                state_d    = ST_RD;
            end
            ST_RD: state_d = ST_WT;
            ST_WT: if (valid_sel) begin
                tx_data_d  = dout_sel;
                tx_valid_d = 1'b1;
                state_d    = ST_DATA;
            end
            ST_DATA: if (tx_hs) begin
                cnt_d = cnt_q + 8'd1;
`ifdef RS422_TX_CSUM_EN
                csum_d = csum_q ^ tx_data_q;
`endif
                if (cnt_q + 8'd1 == len_q) begin
`ifdef RS422_TX_CSUM_EN
                    tx_data_d = csum_q ^ tx_data_q;
                    state_d   = ST_CSUM;
`else
                    tx_valid_d = 1'b0;
                    state_d    = ST_DONE;
`endif
                end else begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_RD;
                end
            end
`ifdef RS422_TX_CSUM_EN
            ST_CSUM: if (tx_hs) begin
                tx_valid_d = 1'b0;
                state_d    = ST_DONE;
            end
`endif
            ST_DONE: begin
                tx_valid_d = 1'b0;
                rr_ptr_d   = (gnt_q == IDXW'(NCH-1)) ? '0 : gnt_q + IDXW'(1);
                state_d    = ST_IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef RS422_TX_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef RS422_TX_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        fifo_load = '0;
        if (state_q == ST_RD) begin
            fifo_load[gnt_q] = 1'b1;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

endmodule
